// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
//
// Parametrised single-clock FIFO with DEPTH = 2**ADDR_WIDTH entries. It keeps
// an exact occupancy count, has run-time programmable almost-empty and
// almost-full thresholds, a registered read port with a valid strobe, and
// overflow/underflow detection. The storage array is internal.
//
// Compile-time option:
//   FIFO_STICKY_ERR_EN  defined     : overflow/underflow are set by an event
//                                      and stay high until Reset is asserted.
//                       not defined : overflow/underflow are registered
//                                      one-cycle pulses, high in the cycle
//                                      after the offending request.
//
// Parameters:
//   DATA_WIDTH   width of the data bus
//   ADDR_WIDTH   pointer width; DEPTH = 2**ADDR_WIDTH
//
// Ports:
//   clk                in   clock; all state changes on posedge
//   Reset              in   synchronous, active-low reset (overrides Enable)
//   Enable             in   global enable; 0 freezes all state
//   write_enable       in   write request
//   read_enable        in   read request
//   FIFO_data_in       in   write data
//   almost_empty_thr   in   almost-empty threshold in entries
//   almost_full_thr    in   almost-full threshold in entries
//   FIFO_data_out      out  registered read data
//   data_valid         out  FIFO_data_out was updated by a read this cycle
//   fill_level         out  current occupancy, 0..DEPTH
//   FIFO_empty         out  fill_level == 0
//   FIFO_full          out  fill_level == DEPTH
//   FIFO_almost_empty  out  fill_level <= almost_empty_thr
//   FIFO_almost_full   out  fill_level >= almost_full_thr
//   overflow           out  write refused (pulse or sticky, see above)
//   underflow          out  read refused (pulse or sticky, see above)
// ---------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  input  logic [ADDR_WIDTH:0]   almost_empty_thr,
  input  logic [ADDR_WIDTH:0]   almost_full_thr,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  FIFO_empty,
  output logic                  FIFO_full,
  output logic                  FIFO_almost_empty,
  output logic                  FIFO_almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // The count is one bit wider than the pointers, so DEPTH itself is simply
  // the top bit set.
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic rd_ok;
  logic wr_ok;
  logic ovf_evt;
  logic unf_evt;

  // Request qualification. A full FIFO still accepts a write when a read is
  // accepted in the same cycle, because the read frees the slot the write
  // lands in. On an empty FIFO the read is refused even if a write arrives,
  // so the incoming word is never passed straight through. Reset gates the
  // accepts so that the array is not written while the FIFO is in reset.
  always_comb begin
    rd_ok   = 1'b0;
    wr_ok   = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (Reset && Enable) begin
      rd_ok   = read_enable && (fill_level != '0);
      wr_ok   = write_enable && ((fill_level != FULL_COUNT) || rd_ok);
      ovf_evt = write_enable && !wr_ok;
      unf_evt = read_enable && !rd_ok;
    end
  end

  // The storage array has no reset; its contents only matter once they are
  // covered by the count.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= FIFO_data_in;
    end
  end

  // Pointers are exactly ADDR_WIDTH bits wide, so they wrap from DEPTH-1 to 0
  // without an explicit compare.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Occupancy counter. A simultaneous accepted read and write leaves the
  // count unchanged.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      fill_level <= '0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10:   fill_level <= fill_level + CNT_ONE;
        2'b01:   fill_level <= fill_level - CNT_ONE;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Registered read port. When a read and a write hit the same slot on a
  // full FIFO, the non-blocking write means the read still picks up the old
  // (oldest) word. data_valid drops while Enable is low because rd_ok is
  // already gated by Enable.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      FIFO_data_out <= '0;
      data_valid    <= 1'b0;
    end else begin
      data_valid <= rd_ok;
      if (rd_ok) begin
        FIFO_data_out <= mem[rd_ptr];
      end
    end
  end

  // Error flags. They hold while Enable is low in both modes and never
  // influence the data path.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (Enable) begin
`ifdef FIFO_STICKY_ERR_EN
      overflow  <= overflow | ovf_evt;
      underflow <= underflow | unf_evt;
`else
      overflow  <= ovf_evt;
      underflow <= unf_evt;
`endif
    end
  end

  // Status flags are combinational, so a threshold change is visible at
  // once. A threshold above DEPTH is legal and just pins the flag.
  always_comb begin
    FIFO_empty        = (fill_level == '0);
    FIFO_full         = (fill_level == FULL_COUNT);
    FIFO_almost_empty = (fill_level <= almost_empty_thr);
    FIFO_almost_full  = (fill_level >= almost_full_thr);
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param
//
// Directed bench for fifo_sync_param with DATA_WIDTH=8 and ADDR_WIDTH=3. A
// table of single-cycle vectors covers fill to full, overflow, simultaneous
// read/write on full, drain, and underflow on empty. Hand-written sequences
// cover pointer wrap with interleaved reads, an Enable freeze, a mid-run
// Reset and immediate threshold changes. Error-flag expectations are given
// as pulses and folded into sticky values when FIFO_STICKY_ERR_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

  logic       clk;
  logic       Reset;
  logic       Enable;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] FIFO_data_in;
  logic [3:0] almost_empty_thr;
  logic [3:0] almost_full_thr;
  logic [7:0] FIFO_data_out;
  logic       data_valid;
  logic [3:0] fill_level;
  logic       FIFO_empty;
  logic       FIFO_full;
  logic       FIFO_almost_empty;
  logic       FIFO_almost_full;
  logic       overflow;
  logic       underflow;

  fifo_sync_param #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk              (clk),
    .Reset            (Reset),
    .Enable           (Enable),
    .write_enable     (write_enable),
    .read_enable      (read_enable),
    .FIFO_data_in     (FIFO_data_in),
    .almost_empty_thr (almost_empty_thr),
    .almost_full_thr  (almost_full_thr),
    .FIFO_data_out    (FIFO_data_out),
    .data_valid       (data_valid),
    .fill_level       (fill_level),
    .FIFO_empty       (FIFO_empty),
    .FIFO_full        (FIFO_full),
    .FIFO_almost_empty(FIFO_almost_empty),
    .FIFO_almost_full (FIFO_almost_full),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dv;
    logic [3:0] fill;
    logic       ovf;
    logic       unf;
  } vec_t;

  localparam int NUM_VECS = 23;

  vec_t vecs [NUM_VECS];

  int checks = 0;
  int errors = 0;

  logic sticky_ovf = 1'b0;
  logic sticky_unf = 1'b0;

  logic [7:0] q [$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_unf;

  function automatic vec_t mk(input logic rst_n, input logic en, input logic we,
                              input logic re, input logic [7:0] din,
                              input logic [7:0] dout, input logic dv,
                              input logic [3:0] fill, input logic ovf,
                              input logic unf);
    vec_t v;
    v.rst_n = rst_n;
    v.en    = en;
    v.we    = we;
    v.re    = re;
    v.din   = din;
    v.dout  = dout;
    v.dv    = dv;
    v.fill  = fill;
    v.ovf   = ovf;
    v.unf   = unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the posedge happen, then settle 1ns.
  task automatic applyStimulus(input logic rst_n, input logic en, input logic we,
                               input logic re, input logic [7:0] din);
    Reset        = rst_n;
    Enable       = en;
    write_enable = we;
    read_enable  = re;
    FIFO_data_in = din;
    @(posedge clk);
    #1;
  endtask

  // p_ovf/p_unf are the pulse-mode expectations; the sticky variant is the
  // running OR of the pulses since the last reset.
  task automatic checkOutput(input string tag, input logic [7:0] e_dout,
                             input logic e_dv, input logic [3:0] e_fill,
                             input logic p_ovf, input logic p_unf,
                             input logic was_reset);
    logic e_ovf;
    logic e_unf;
    if (was_reset) begin
      sticky_ovf = 1'b0;
      sticky_unf = 1'b0;
    end else begin
      sticky_ovf = sticky_ovf | p_ovf;
      sticky_unf = sticky_unf | p_unf;
    end
`ifdef FIFO_STICKY_ERR_EN
    e_ovf = sticky_ovf;
    e_unf = sticky_unf;
`else
    e_ovf = p_ovf;
    e_unf = p_unf;
`endif
    chk({tag, " data_out"}, 32'(FIFO_data_out), 32'(e_dout));
    chk({tag, " data_valid"}, 32'(data_valid), 32'(e_dv));
    chk({tag, " fill_level"}, 32'(fill_level), 32'(e_fill));
    chk({tag, " empty"}, 32'(FIFO_empty), 32'(e_fill == 4'd0));
    chk({tag, " full"}, 32'(FIFO_full), 32'(e_fill == 4'd8));
    chk({tag, " almost_empty"}, 32'(FIFO_almost_empty), 32'(e_fill <= almost_empty_thr));
    chk({tag, " almost_full"}, 32'(FIFO_almost_full), 32'(e_fill >= almost_full_thr));
    chk({tag, " overflow"}, 32'(overflow), 32'(e_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(e_unf));
  endtask

  // One normal (Reset released) cycle checked against the queue model.
  task automatic step(input logic en, input logic we, input logic re,
                      input logic [7:0] din, input string tag);
    logic rd_ok;
    logic wr_ok;
    rd_ok = en && re && (q.size() != 0);
    wr_ok = en && we && ((q.size() != 8) || rd_ok);
    if (en) begin
      m_ovf = we && !wr_ok;
      m_unf = re && !rd_ok;
    end
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    applyStimulus(1'b1, en, we, re, din);
    checkOutput(tag, m_dout, rd_ok, 4'(q.size()), m_ovf, m_unf, 1'b0);
  endtask

  initial begin
    Reset            = 1'b0;
    Enable           = 1'b1;
    write_enable     = 1'b0;
    read_enable      = 1'b0;
    FIFO_data_in     = 8'h00;
    almost_empty_thr = 4'd2;
    almost_full_thr  = 4'd6;

    // rst_n en we re din     dout   dv fill ovf unf
    vecs[0] = mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 4'd0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      vecs[i] = mk(1, 1, 1, 0, 8'(8'h11 * i), 8'h00, 0, 4'(i), 0, 0);
    end
    vecs[9]  = mk(1, 1, 1, 0, 8'h99, 8'h00, 0, 4'd8, 1, 0);
    vecs[10] = mk(1, 1, 1, 1, 8'hA1, 8'h11, 1, 4'd8, 0, 0);
    for (int k = 0; k < 7; k++) begin
      vecs[11 + k] = mk(1, 1, 0, 1, 8'h00, 8'(8'h11 * (k + 2)), 1, 4'(7 - k), 0, 0);
    end
    vecs[18] = mk(1, 1, 0, 1, 8'h00, 8'hA1, 1, 4'd0, 0, 0);
    vecs[19] = mk(1, 1, 0, 1, 8'h00, 8'hA1, 0, 4'd0, 0, 1);
    vecs[20] = mk(1, 1, 1, 1, 8'hB2, 8'hA1, 0, 4'd1, 0, 1);
    vecs[21] = mk(1, 1, 0, 0, 8'h00, 8'hA1, 0, 4'd1, 0, 0);
    vecs[22] = mk(1, 1, 0, 1, 8'h00, 8'hB2, 1, 4'd0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].we, vecs[i].re, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].dout, vecs[i].dv, vecs[i].fill,
                  vecs[i].ovf, vecs[i].unf, !vecs[i].rst_n);
    end

    // Model state matching the end of the table.
    q.delete();
    m_dout = 8'hB2;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;

    // 20 writes with reads from the third cycle on: pointers wrap twice.
    // Three frozen cycles with both requests raised sit in the middle.
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        for (int j = 0; j < 3; j++) begin
          step(1'b0, 1'b1, 1'b1, 8'hEE, $sformatf("freeze%0d", j));
        end
      end
      step(1'b1, 1'b1, (i >= 2), 8'(8'hC0 + i), $sformatf("wrap%0d", i));
    end
    step(1'b1, 1'b0, 1'b1, 8'h00, "drain0");
    step(1'b1, 1'b0, 1'b1, 8'h00, "drain1");
    step(1'b1, 1'b0, 1'b1, 8'h00, "drain_empty");

    // Mid-run reset with requests still raised; all state must clear.
    step(1'b1, 1'b1, 1'b0, 8'h5A, "pre_rst0");
    step(1'b1, 1'b1, 1'b0, 8'h5B, "pre_rst1");
    step(1'b1, 1'b1, 1'b0, 8'h5C, "pre_rst2");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    checkOutput("mid_reset", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h3C, "post_rst_wr");
    step(1'b1, 1'b0, 1'b1, 8'h00, "post_rst_rd");

    // Thresholds act combinationally, with no clock edge in between.
    almost_empty_thr = 4'd9;
    almost_full_thr  = 4'd0;
    #1;
    chk("thr ae above depth", 32'(FIFO_almost_empty), 32'd1);
    chk("thr af zero", 32'(FIFO_almost_full), 32'd1);
    almost_full_thr = 4'd9;
    #1;
    chk("thr af above depth", 32'(FIFO_almost_full), 32'd0);
    almost_empty_thr = 4'd2;
    almost_full_thr  = 4'd6;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
